// File: rtl/fb_pkg.sv
// rtl/fb_pkg.sv - shared encodings and sizing helper for the frame buffer
package fb_pkg;

    typedef enum logic [1:0] {
        FB_OP_NOP   = 2'b00,
        FB_OP_WRITE = 2'b01,
        FB_OP_READ  = 2'b10,
        FB_OP_CLEAR = 2'b11
    } fb_op_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WRITE,
        ST_READ,
        ST_DRAIN,
        ST_CLEAR
    } fb_state_e;

    function automatic int fb_depth(input int img_w, input int img_h, input int channels);
        return img_w * img_h * channels;
    endfunction

endpackage

// File: rtl/fb_sp_ram.sv
// rtl/fb_sp_ram.sv - single-port synchronous RAM with registered read data
module fb_sp_ram #(
    parameter int PIX_W = 8,
    parameter int DEPTH = 24,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             i_we,
    input  logic             i_re,
    input  logic [AW-1:0]    i_addr,
    input  logic [PIX_W-1:0] i_wdata,
    output logic [PIX_W-1:0] o_rdata
);

    logic [PIX_W-1:0] r_mem [DEPTH];
    logic [PIX_W-1:0] r_rdata;

    // Read data only changes on a read, so it holds naturally under backpressure.
    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_addr] <= i_wdata;
        end else if (i_re) begin
            r_rdata <= r_mem[i_addr];
        end
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/frame_buffer_rw.sv
// rtl/frame_buffer_rw.sv - command-driven frame store: camera fill, stream drain, zero-fill
module frame_buffer_rw
    import fb_pkg::*;
#(
    parameter int PIX_W    = 8,
    parameter int CHANNELS = 3,
    parameter int IMG_W    = 320,
    parameter int IMG_H    = 480
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_cmd_valid,
    input  logic [1:0]       i_cmd_op,
    output logic             o_cmd_ready,
    input  logic             i_abort,
    input  logic             i_in_valid,
    input  logic [PIX_W-1:0] i_in_data,
    output logic             o_in_ready,
    output logic             o_out_valid,
    output logic [PIX_W-1:0] o_out_data,
    input  logic             i_out_ready,
    output logic             o_out_last,
    output logic             o_done,
    output logic             o_busy,
    output logic             o_err_op
);

    localparam int DEPTH = fb_depth(IMG_W, IMG_H, CHANNELS);
    localparam int AW    = $clog2(DEPTH);

    fb_state_e        r_state;
    fb_state_e        w_state_nx;
    logic [AW-1:0]    r_addr;
    logic             r_out_valid;
    logic             r_out_last;
    logic             r_done;
    logic             r_err_op;
    logic             w_we;
    logic             w_re;
    logic             w_inc;
    logic             w_accept;
    logic             w_done_nx;
    logic             w_err_nx;
    logic             w_abort;
    logic             w_addr_last;
    logic [PIX_W-1:0] w_wdata;
    logic [PIX_W-1:0] w_rdata;
    fb_op_e           w_op;

    assign w_op        = fb_op_e'(i_cmd_op);
    assign w_addr_last = (r_addr == AW'(DEPTH - 1));
    assign w_abort     = i_abort && (r_state != ST_IDLE);
    assign w_err_nx    = i_cmd_valid && ((r_state != ST_IDLE) || (w_op == FB_OP_NOP));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nx;
        end
    end

    always_comb begin
        w_state_nx = r_state;
        w_we       = 1'b0;
        w_re       = 1'b0;
        w_inc      = 1'b0;
        w_accept   = 1'b0;
        w_done_nx  = 1'b0;
        w_wdata    = i_in_data;
        case (r_state)
            ST_IDLE: begin
                if (i_cmd_valid) begin
                    w_accept = 1'b1;
                    case (w_op)
                        FB_OP_WRITE: w_state_nx = ST_WRITE;
                        FB_OP_READ:  w_state_nx = ST_READ;
                        FB_OP_CLEAR: w_state_nx = ST_CLEAR;
                        default:     w_state_nx = ST_IDLE;
                    endcase
                end
            end
            ST_WRITE: begin
                if (i_in_valid) begin
                    w_we  = 1'b1;
                    w_inc = 1'b1;
                    if (w_addr_last) begin
                        w_state_nx = ST_IDLE;
                        w_done_nx  = 1'b1;
                    end
                end
            end
            ST_READ: begin
                // Issue a read whenever the output register is empty or being emptied.
                w_re  = !r_out_valid || i_out_ready;
                w_inc = w_re;
                if (w_re && w_addr_last) begin
                    w_state_nx = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (r_out_valid && i_out_ready && r_out_last) begin
                    w_state_nx = ST_IDLE;
                    w_done_nx  = 1'b1;
                end
            end
            ST_CLEAR: begin
                w_we    = 1'b1;
                w_inc   = 1'b1;
                w_wdata = '0;
                if (w_addr_last) begin
                    w_state_nx = ST_IDLE;
                    w_done_nx  = 1'b1;
                end
            end
            default: w_state_nx = ST_IDLE;
        endcase
        if (w_abort) begin
            w_state_nx = ST_IDLE;
            w_done_nx  = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_addr      <= '0;
            r_out_valid <= 1'b0;
            r_out_last  <= 1'b0;
            r_done      <= 1'b0;
            r_err_op    <= 1'b0;
        end else begin
            r_done   <= w_done_nx;
            r_err_op <= w_err_nx;
            if (w_accept) begin
                r_addr <= '0;
            end else if (w_inc) begin
                r_addr <= w_addr_last ? '0 : r_addr + 1'b1;
            end
            if (w_abort) begin
                r_out_valid <= 1'b0;
            end else if (w_re) begin
                r_out_valid <= 1'b1;
            end else if (i_out_ready) begin
                r_out_valid <= 1'b0;
            end
            if (w_re) begin
                r_out_last <= w_addr_last;
            end
        end
    end

    fb_sp_ram #(
        .PIX_W (PIX_W),
        .DEPTH (DEPTH)
    ) u_ram (
        .clk     (clk),
        .i_we    (w_we),
        .i_re    (w_re),
        .i_addr  (r_addr),
        .i_wdata (w_wdata),
        .o_rdata (w_rdata)
    );

    assign o_cmd_ready = (r_state == ST_IDLE);
    assign o_busy      = (r_state != ST_IDLE);
    assign o_in_ready  = (r_state == ST_WRITE);
    assign o_out_valid = r_out_valid;
    assign o_out_data  = r_out_valid ? w_rdata : '0;
    assign o_out_last  = r_out_valid && r_out_last;
    assign o_done      = r_done;
    assign o_err_op    = r_err_op;

endmodule

// File: tb/tb_frame_buffer_rw.sv
// tb/tb_frame_buffer_rw.sv - self-checking bench for frame_buffer_rw against an array model
module tb_frame_buffer_rw;

    localparam int N = 24;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       i_cmd_valid;
    logic [1:0] i_cmd_op;
    logic       o_cmd_ready;
    logic       i_abort;
    logic       i_in_valid;
    logic [7:0] i_in_data;
    logic       o_in_ready;
    logic       o_out_valid;
    logic [7:0] o_out_data;
    logic       i_out_ready;
    logic       o_out_last;
    logic       o_done;
    logic       o_busy;
    logic       o_err_op;

    logic [7:0] ref_mem [N];
    logic [7:0] wbuf [N];
    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    frame_buffer_rw #(.PIX_W(8), .CHANNELS(3), .IMG_W(4), .IMG_H(2)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_cmd_valid (i_cmd_valid),
        .i_cmd_op    (i_cmd_op),
        .o_cmd_ready (o_cmd_ready),
        .i_abort     (i_abort),
        .i_in_valid  (i_in_valid),
        .i_in_data   (i_in_data),
        .o_in_ready  (o_in_ready),
        .o_out_valid (o_out_valid),
        .o_out_data  (o_out_data),
        .i_out_ready (i_out_ready),
        .o_out_last  (o_out_last),
        .o_done      (o_done),
        .o_busy      (o_busy),
        .o_err_op    (o_err_op)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_cmd(input logic [1:0] op);
        n_checks++;
        if (o_cmd_ready !== 1'b1) begin
            n_errors++;
            $display("FAIL cmd_ready_before_cmd: got %b expected 1", o_cmd_ready);
        end
        i_cmd_valid = 1'b1;
        i_cmd_op    = op;
        step();
        i_cmd_valid = 1'b0;
        i_cmd_op    = 2'b00;
        n_checks++;
        if (o_busy !== 1'b1) begin
            n_errors++;
            $display("FAIL busy_after_cmd: got %b expected 1", o_busy);
        end
    endtask

    task automatic write_frame(input int abort_at, input bit gaps);
        int beats = 0;
        int cyc = 0;
        int rdy = 0;
        bit v;
        do_cmd(2'b01);
        while (beats < N && cyc < 1000) begin
            n_checks++;
            if (o_done !== 1'b0) begin
                n_errors++;
                $display("FAIL wr_early_done: got %b expected 0 at beat %0d", o_done, beats);
            end
            if (o_in_ready === 1'b1) rdy++;
            if (beats == abort_at) begin
                i_abort    = 1'b1;
                i_in_valid = 1'b0;
                step();
                i_abort = 1'b0;
                break;
            end
            v = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
            i_in_valid = v;
            i_in_data  = wbuf[beats];
            step();
            cyc++;
            if (v) begin
                ref_mem[beats] = wbuf[beats];
                beats++;
            end
        end
        i_in_valid = 1'b0;
        if (abort_at < N) begin
            n_checks++;
            if (o_busy !== 1'b0 || o_cmd_ready !== 1'b1 || o_done !== 1'b0) begin
                n_errors++;
                $display("FAIL wr_abort_state: got busy=%b ready=%b done=%b expected 0 1 0", o_busy, o_cmd_ready, o_done);
            end
            step();
            n_checks++;
            if (o_done !== 1'b0) begin
                n_errors++;
                $display("FAIL wr_abort_late_done: got %b expected 0", o_done);
            end
        end else begin
            n_checks++;
            if (beats != N || rdy != cyc) begin
                n_errors++;
                $display("FAIL wr_beats: got beats=%0d ready_cycles=%0d expected %0d %0d", beats, rdy, N, cyc);
            end
            if (!gaps) begin
                n_checks++;
                if (cyc != N) begin
                    n_errors++;
                    $display("FAIL wr_cycles: got %0d expected %0d", cyc, N);
                end
            end
            n_checks++;
            if (o_done !== 1'b1 || o_cmd_ready !== 1'b1 || o_in_ready !== 1'b0) begin
                n_errors++;
                $display("FAIL wr_done: got done=%b ready=%b in_ready=%b expected 1 1 0", o_done, o_cmd_ready, o_in_ready);
            end
            step();
            n_checks++;
            if (o_done !== 1'b0) begin
                n_errors++;
                $display("FAIL wr_done_width: got %b expected 0", o_done);
            end
        end
    endtask

    // mode 0: always ready, 1: ready pattern 1,0,0,1, 2: random ready
    task automatic read_frame(input int mode, input int inj_cyc);
        int idx = 0;
        int cyc = 0;
        int errs = 0;
        bit r;
        bit acc;
        bit err_exp = 1'b0;
        do_cmd(2'b10);
        while (idx < N && cyc < 1000) begin
            if (o_out_valid === 1'b1) begin
                if (o_out_data !== ref_mem[idx] || o_out_last !== (idx == N - 1)) errs++;
                if (o_out_data !== ref_mem[idx] || o_out_last !== (idx == N - 1))
                    $display("FAIL rd_sample%0d: got data=%h last=%b expected %h %b", idx, o_out_data, o_out_last, ref_mem[idx], idx == N - 1);
            end else if (o_out_data !== 8'h00 || o_out_last !== 1'b0) begin
                errs++;
                $display("FAIL rd_idle_out: got data=%h last=%b expected 00 0", o_out_data, o_out_last);
            end
            if (o_done !== 1'b0 || o_err_op !== err_exp) begin
                errs++;
                $display("FAIL rd_flags: got done=%b err_op=%b expected 0 %b", o_done, o_err_op, err_exp);
            end
            case (mode)
                0:       r = 1'b1;
                1:       r = (cyc % 4 == 0) || (cyc % 4 == 3);
                default: r = 1'($urandom_range(0, 1));
            endcase
            i_out_ready = r;
            err_exp     = (cyc == inj_cyc);
            i_cmd_valid = err_exp;
            i_cmd_op    = 2'b01;
            acc         = (o_out_valid === 1'b1) && r;
            step();
            cyc++;
            if (acc) idx++;
        end
        i_cmd_valid = 1'b0;
        i_cmd_op    = 2'b00;
        i_out_ready = 1'b0;
        n_checks++;
        if (errs != 0) begin
            n_errors++;
            $display("FAIL rd_stream_mode%0d: got %0d bad cycles expected 0", mode, errs);
        end
        n_checks++;
        if (idx != N) begin
            n_errors++;
            $display("FAIL rd_count: got %0d samples expected %0d", idx, N);
        end
        if (mode == 0) begin
            n_checks++;
            if (cyc != N + 1) begin
                n_errors++;
                $display("FAIL rd_throughput: got %0d cycles expected %0d", cyc, N + 1);
            end
        end
        n_checks++;
        if (o_done !== 1'b1 || o_out_valid !== 1'b0) begin
            n_errors++;
            $display("FAIL rd_done: got done=%b out_valid=%b expected 1 0", o_done, o_out_valid);
        end
        step();
        n_checks++;
        if (o_done !== 1'b0 || o_cmd_ready !== 1'b1) begin
            n_errors++;
            $display("FAIL rd_after_done: got done=%b ready=%b expected 0 1", o_done, o_cmd_ready);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        i_cmd_valid = 1'b0;
        i_cmd_op = 2'b00;
        i_abort = 1'b0;
        i_in_valid = 1'b0;
        i_in_data = 8'h00;
        i_out_ready = 1'b0;
        repeat (3) step();
        n_checks++;
        if ({o_cmd_ready, o_busy, o_in_ready, o_out_valid, o_out_last, o_done, o_err_op} !== 7'b1000000
            || o_out_data !== 8'h00) begin
            n_errors++;
            $display("FAIL reset_outputs: got %b/%h expected 1000000/00",
                {o_cmd_ready, o_busy, o_in_ready, o_out_valid, o_out_last, o_done, o_err_op}, o_out_data);
        end
        rst_n = 1'b1;
        step();
        n_checks++;
        if (o_cmd_ready !== 1'b1 || o_busy !== 1'b0) begin
            n_errors++;
            $display("FAIL reset_release: got ready=%b busy=%b expected 1 0", o_cmd_ready, o_busy);
        end
    endtask

    task automatic test_write_continuous();
        for (int i = 0; i < N; i++) wbuf[i] = 8'(8'h10 + i);
        write_frame(N, 1'b0);
    endtask

    task automatic test_clear_then_read();
        int cyc = 0;
        do_cmd(2'b11);
        while (o_done !== 1'b1 && cyc < 200) begin
            step();
            cyc++;
        end
        n_checks++;
        if (cyc != N) begin
            n_errors++;
            $display("FAIL clr_cycles: got %0d expected %0d", cyc, N);
        end
        for (int i = 0; i < N; i++) ref_mem[i] = 8'h00;
        step();
        read_frame(0, -1);
    endtask

    task automatic test_abort();
        for (int i = 0; i < N; i++) wbuf[i] = 8'($urandom);
        write_frame(N, 1'b1);
        for (int i = 0; i < N; i++) wbuf[i] = 8'($urandom);
        write_frame(10, 1'b0);
        read_frame(2, -1);
    endtask

    task automatic test_errors();
        i_cmd_valid = 1'b1;
        i_cmd_op = 2'b00;
        step();
        i_cmd_valid = 1'b0;
        n_checks++;
        if (o_err_op !== 1'b1 || o_busy !== 1'b0) begin
            n_errors++;
            $display("FAIL nop_err: got err_op=%b busy=%b expected 1 0", o_err_op, o_busy);
        end
        step();
        n_checks++;
        if (o_err_op !== 1'b0) begin
            n_errors++;
            $display("FAIL nop_err_width: got %b expected 0", o_err_op);
        end
        i_cmd_valid = 1'b1;
        i_cmd_op = 2'b01;
        i_abort = 1'b1;
        step();
        i_cmd_valid = 1'b0;
        i_abort = 1'b0;
        n_checks++;
        if (o_busy !== 1'b1 || o_in_ready !== 1'b1) begin
            n_errors++;
            $display("FAIL abort_idle_cmd: got busy=%b in_ready=%b expected 1 1", o_busy, o_in_ready);
        end
        i_abort = 1'b1;
        step();
        i_abort = 1'b0;
        n_checks++;
        if (o_busy !== 1'b0 || o_done !== 1'b0) begin
            n_errors++;
            $display("FAIL abort_write: got busy=%b done=%b expected 0 0", o_busy, o_done);
        end
        read_frame(1, 5);
    endtask

    task automatic test_reset_mid();
        do_cmd(2'b10);
        i_out_ready = 1'b0;
        repeat (3) step();
        n_checks++;
        if (o_out_valid !== 1'b1) begin
            n_errors++;
            $display("FAIL mid_pending: got out_valid=%b expected 1", o_out_valid);
        end
        #2 rst_n = 1'b0;
        #1;
        n_checks++;
        if (o_out_valid !== 1'b0 || o_busy !== 1'b0 || o_cmd_ready !== 1'b1 || o_out_data !== 8'h00) begin
            n_errors++;
            $display("FAIL mid_reset: got valid=%b busy=%b ready=%b data=%h expected 0 0 1 00",
                o_out_valid, o_busy, o_cmd_ready, o_out_data);
        end
        step();
        rst_n = 1'b1;
        step();
    endtask

    initial begin
        test_reset();
        test_write_continuous();
        read_frame(0, -1);
        read_frame(1, -1);
        test_clear_then_read();
        test_abort();
        test_errors();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
